// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch front end: widths, constants,
// fetch FSM encoding, queue entry layout and small PC helpers.
package cpu_pkg;

    localparam int          INST_W   = 32;
    localparam int          PC_W     = 32;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    // One prefetch queue entry: PC in the upper word, instruction in the lower.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instruction fetches are always word aligned.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

    // Sequential next PC; wraps silently at the top of the address space.
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_prefetch_sync_fifo.sv
// Small synchronous FIFO used as the prefetch queue. Flush empties it and has
// priority over push/pop. A push into a full queue is only taken when a pop
// frees a slot in the same cycle, so entries are never overwritten.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == {CNT_W{1'b0}});
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers; contents cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end. Issues sequential word fetches over a req/ack
// interface with at most one request outstanding, queues returned {pc,inst}
// pairs and presents the queue head to decode. A redirect flushes the queue;
// a request already on the bus is allowed to finish and its data is dropped.
module if_prefetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        pcrst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      addr_q, addr_d;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W-1:0] cnt_after_s;
    logic [63:0]      head_raw_s;
    fetch_entry_t     head_s;
    fetch_entry_t     push_entry_s;

    assign head_s       = fetch_entry_t'(head_raw_s);
    assign push_entry_s = '{pc: fetch_pc_q, inst: imem_rdata};

    // A redirect discards the head, so nothing is consumed in that cycle.
    assign pop_s = ~empty_s & id_ready & ~redirect;

    // Occupancy once this cycle's fetch lands and any pop is taken.
    assign cnt_after_s = count_s + {{(CNT_W-1){1'b0}}, 1'b1} - {{(CNT_W-1){1'b0}}, pop_s};

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (pcrst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect),
        .din   (push_entry_s),
        .dout  (head_raw_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Fetch FSM: next state, next fetch PC, queue push and bus address.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = align_pc(redirect_pc);
                    state_d    = ST_FETCH;
                end else if (~full_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    // Data acked alongside a redirect is stale; if the bus is
                    // still busy, wait it out in DISCARD.
                    fetch_pc_d = align_pc(redirect_pc);
                    state_d    = imem_ack ? ST_FETCH : ST_DISCARD;
                end else if (imem_ack) begin
                    push_s     = 1'b1;
                    fetch_pc_d = next_pc(fetch_pc_q);
                    state_d    = (cnt_after_s < CNT_W'(DEPTH)) ? ST_FETCH : ST_IDLE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = align_pc(redirect_pc);
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                state_d = imem_ack ? ST_IDLE : ST_DISCARD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Address is captured only when a new request starts, so it stays
        // stable for the whole of an outstanding request, discarded or not.
        if (state_d == ST_FETCH) begin
            addr_d = fetch_pc_d;
        end else begin
            addr_d = addr_q;
        end
    end

    // FSM, fetch PC and bus address registers.
    always_ff @(posedge clk or posedge pcrst) begin
        if (pcrst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
    assign imem_addr = addr_q;

    assign id_valid = ~empty_s;
    assign id_pc    = empty_s ? 32'h0000_0000 : head_s.pc;
    assign id_inst  = empty_s ? NOP_INST : head_s.inst;

endmodule
